rs_issue_sched: RTL
===================

# rs_issue_sched

Issue scheduler for the reservation station. Each cycle it picks, per functional unit (ALU, MUL, LSU), the oldest entry that is valid, has both operands ready, and targets that unit. It then issues a registered request to the unit and returns a one-hot clear to the RS so the entry is freed. It tracks allocation age, the busy window of the non-pipelined multiplier, and the valid/ack handshake of the LSU.

## Interface
Parameters:
- RS_SIZE, 4, number of RS entries
- IDXW, $clog2(RS_SIZE), entry index width
- MUL_LAT, 3, multiplier occupancy in cycles (≥1)

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  reset; one clock, reset is asynchronous and active-low
- alloc_en_i  in  1  entry allocated this cycle
- alloc_idx_i  in  IDXW  index of allocated entry
- entry_valid_i  in  RS_SIZE  entry occupied
- entry_ready_i  in  RS_SIZE  both source operands ready
- entry_fu_i  in  2*RS_SIZE  FU type per entry, bits [2i+1:2i]; 00 ALU, 01 MUL, 10 LSU, 11 none
- alu_valid_i  in  1  ALU can accept this cycle
- mul_valid_i  in  1  MUL unit enabled
- lsu_ack_i  in  1  LSU accepts the held request
- alu_request_o  out  1  one-cycle ALU issue pulse
- alu_idx_o  out  IDXW  entry issued to ALU
- mul_request_o  out  1  one-cycle MUL issue pulse
- mul_idx_o  out  IDXW  entry issued to MUL
- mul_busy_o  out  1  multiplier occupied
- lsu_request_o  out  1  LSU request, held until ack
- lsu_idx_o  out  IDXW  entry offered to LSU
- issue_clr_o  out  RS_SIZE  one-hot-per-FU clear pulses; the RS frees these entries

## Operation
- Age matrix `age[j][i]` = 1 means j is older than i.
  - On alloc_en_i with index k: `age[k][*]` ← 0, and `age[j][k]` ← 1 for all j≠k.
  - Reset value is all zeros.
- Eligibility: `elig = entry_valid_i & entry_ready_i & ~inflight`.
  - `inflight` = issue_clr_o | (lsu_request_o ? onehot(lsu_idx_o) : 0).
- Per FU f, candidates are elig entries whose type is f. The winner is the candidate i with no candidate j where `age[j][i]`=1. Ties (equal age after reset) go to the lowest index.
- ALU: a candidate exists and alu_valid_i=1 → register alu_request_o=1, alu_idx_o=winner, and set that bit of issue_clr_o.
- MUL: a candidate exists, mul_valid_i=1, and mul_cnt==0 → register mul_request_o=1, mul_idx_o, the clr bit, and mul_cnt←MUL_LAT.
  - mul_cnt decrements to 0 each cycle otherwise.
  - mul_busy_o = (mul_cnt!=0).
- LSU FSM, states IDLE and WAIT:
  - IDLE with a candidate → WAIT; lsu_request_o=1, lsu_idx_o latched.
  - WAIT & lsu_ack_i → IDLE; request drops and the issue_clr_o bit pulses next cycle.
  - WAIT & !lsu_ack_i → hold. lsu_idx_o must be stable and the entry is never cleared.
  - No new LSU select in the cycle the ack is seen; the earliest next select is the following cycle.
- Entries of type 11 are never selected.
- alloc_en_i in the same cycle as an issue_clr_o pulse on the same index: the age update applies. The RS resolves alloc-over-clear.
- Async reset mid-operation: all state and outputs clear immediately. A pending LSU request is dropped without a clear.

## Timing
- Reset values: every output is 0; mul_cnt=0; LSU FSM=IDLE; age=0.
- Select is combinational in cycle t. Request, idx and clr are registered and visible in cycle t+1.
- ALU/MUL request and clr are single-cycle pulses in the same cycle. The RS removes the entry at the edge ending t+1; `inflight` masks it during t+1.
- Back-to-back ALU issues from different entries are possible every cycle.
- Successive MUL requests are spaced MUL_LAT+1 cycles apart (4 at default).
- The three FUs issue independently; up to three clr bits can be set in one cycle.
- LSU clr appears in cycle t+1 after the ack cycle t.

## Structure
- Shared package `ooo_pkg`:
  - FU type localparams FU_ALU=2'b00, FU_MUL=2'b01, FU_LSU=2'b10, FU_NONE=2'b11
  - RS_SIZE default
  - LSU FSM state enum
- Sub-module `rs_oldest_pick`: a combinational pick (candidate vector and age matrix in; valid and index out), instantiated once per FU.

## Test plan
- Reset mid-operation: assert reset_ni low with lsu_request_o=1 → all outputs 0 asynchronously, no issue_clr_o pulse after release.
- Alloc order 2, 0, 1, all ALU, ready in the same cycle, alu_valid_i=1 → alu_idx_o 2, 0, 1 on three consecutive cycles; issue_clr_o 0100, 0001, 0010.
- Entries 0 and 1 MUL, ready at t → mul_request_o at t+1 (idx 0) and t+5 (idx 1); mul_busy_o high for t+1..t+3.
- LSU entry 3 ready, lsu_ack_i low 3 cycles then high → lsu_request_o held 4 cycles with idx 3; issue_clr_o=1000 only in the cycle after the ack.
- ALU entry 0, MUL entry 1, LSU entry 2 ready together, ack=1 → all three requests in the same cycle with issue_clr_o=0011; bit 2 pulses one cycle later.
- alu_valid_i=0 with an ALU entry ready → no request and no clr; issue one cycle after alu_valid_i rises.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared definitions for the out-of-order issue logic.
//   FU_*             : 2-bit functional-unit type codes carried per RS entry
//   RS_SIZE_DEFAULT  : default number of reservation-station entries
//   lsu_state_e      : LSU request handshake states
package ooo_pkg;

  localparam logic [1:0] FU_ALU  = 2'b00;
  localparam logic [1:0] FU_MUL  = 2'b01;
  localparam logic [1:0] FU_LSU  = 2'b10;
  localparam logic [1:0] FU_NONE = 2'b11;

  localparam int unsigned RS_SIZE_DEFAULT = 4;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_WAIT = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/rs_oldest_pick.sv
// Combinational oldest-entry picker.
//   i_cand  : candidate entries
//   i_age   : age matrix, i_age[j][i]=1 means entry j is older than entry i
//   o_valid : at least one candidate exists
//   o_idx   : oldest candidate; equal-age ties resolve to the lowest index
module rs_oldest_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]        i_cand,
  input  logic [N-1:0][N-1:0] i_age,
  output logic                o_valid,
  output logic [IW-1:0]       o_idx
);

  logic [N-1:0] w_oldest;

  // An entry is oldest when no other candidate is marked older than it.
  always_comb begin
    w_oldest = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_oldest[i] = i_cand[i];
      for (int unsigned j = 0; j < N; j++) begin
        if (i_cand[j] && i_age[j][i]) begin
          w_oldest[i] = 1'b0;
        end
      end
    end
  end

  // Scan from the top so the lowest-index oldest entry is the final assignment.
  always_comb begin
    o_valid = |w_oldest;
    o_idx   = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (w_oldest[i-1]) begin
        o_idx = IW'(i - 1);
      end
    end
  end

endmodule

// File: rtl/rs_issue_sched.sv
// Reservation-station issue scheduler.
// Picks, per functional unit, the oldest valid+ready entry of that unit type,
// issues a registered request and returns a one-hot clear so the RS frees it.
//   clk_i, reset_ni          : clock, asynchronous active-low reset
//   alloc_en_i, alloc_idx_i  : entry allocation (updates age order)
//   entry_valid_i/ready_i    : per-entry occupancy and operand readiness
//   entry_fu_i               : per-entry FU type, bits [2i+1:2i]
//   alu_valid_i              : ALU can accept this cycle
//   mul_valid_i              : MUL unit enabled
//   lsu_ack_i                : LSU accepts the held request
//   alu_request_o/alu_idx_o  : one-cycle ALU issue
//   mul_request_o/mul_idx_o  : one-cycle MUL issue; mul_busy_o while occupied
//   lsu_request_o/lsu_idx_o  : LSU request held until ack
//   issue_clr_o              : entries the RS frees this cycle
module rs_issue_sched
  import ooo_pkg::*;
#(
  parameter int unsigned RS_SIZE = RS_SIZE_DEFAULT,
  parameter int unsigned IDXW    = $clog2(RS_SIZE),
  parameter int unsigned MUL_LAT = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   alloc_en_i,
  input  logic [IDXW-1:0]        alloc_idx_i,
  input  logic [RS_SIZE-1:0]     entry_valid_i,
  input  logic [RS_SIZE-1:0]     entry_ready_i,
  input  logic [2*RS_SIZE-1:0]   entry_fu_i,
  input  logic                   alu_valid_i,
  input  logic                   mul_valid_i,
  input  logic                   lsu_ack_i,
  output logic                   alu_request_o,
  output logic [IDXW-1:0]        alu_idx_o,
  output logic                   mul_request_o,
  output logic [IDXW-1:0]        mul_idx_o,
  output logic                   mul_busy_o,
  output logic                   lsu_request_o,
  output logic [IDXW-1:0]        lsu_idx_o,
  output logic [RS_SIZE-1:0]     issue_clr_o
);

  localparam int unsigned CNTW = $clog2(MUL_LAT + 1);

  logic [RS_SIZE-1:0][RS_SIZE-1:0] r_age;

  logic                r_alu_req;
  logic [IDXW-1:0]     r_alu_idx;
  logic                r_mul_req;
  logic [IDXW-1:0]     r_mul_idx;
  logic [CNTW-1:0]     r_mul_cnt;
  lsu_state_e          r_lsu_state;
  lsu_state_e          w_lsu_state_nxt;
  logic [IDXW-1:0]     r_lsu_idx;
  logic [RS_SIZE-1:0]  r_clr;

  logic [RS_SIZE-1:0]  w_inflight;
  logic [RS_SIZE-1:0]  w_elig;
  logic [RS_SIZE-1:0]  w_cand_alu;
  logic [RS_SIZE-1:0]  w_cand_mul;
  logic [RS_SIZE-1:0]  w_cand_lsu;

  logic                w_alu_found;
  logic [IDXW-1:0]     w_alu_pick;
  logic                w_mul_found;
  logic [IDXW-1:0]     w_mul_pick;
  logic                w_lsu_found;
  logic [IDXW-1:0]     w_lsu_pick;

  logic                w_alu_fire;
  logic                w_mul_fire;
  logic                w_lsu_load;
  logic                w_lsu_done;
  logic [RS_SIZE-1:0]  w_clr_nxt;

  // Entries already cleared (RS frees them at the end of this cycle) or held
  // by the LSU must not be picked again.
  always_comb begin
    w_inflight = r_clr;
    if (r_lsu_state == LSU_WAIT) begin
      w_inflight = w_inflight | (RS_SIZE'(1) << r_lsu_idx);
    end
    w_elig     = entry_valid_i & entry_ready_i & ~w_inflight;
    w_cand_alu = '0;
    w_cand_mul = '0;
    w_cand_lsu = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      case (entry_fu_i[2*i +: 2])
        FU_ALU:  w_cand_alu[i] = w_elig[i];
        FU_MUL:  w_cand_mul[i] = w_elig[i];
        FU_LSU:  w_cand_lsu[i] = w_elig[i];
        default: ;
      endcase
    end
  end

  rs_oldest_pick #(.N(RS_SIZE), .IW(IDXW)) u_pick_alu (
    .i_cand  (w_cand_alu),
    .i_age   (r_age),
    .o_valid (w_alu_found),
    .o_idx   (w_alu_pick)
  );

  rs_oldest_pick #(.N(RS_SIZE), .IW(IDXW)) u_pick_mul (
    .i_cand  (w_cand_mul),
    .i_age   (r_age),
    .o_valid (w_mul_found),
    .o_idx   (w_mul_pick)
  );

  rs_oldest_pick #(.N(RS_SIZE), .IW(IDXW)) u_pick_lsu (
    .i_cand  (w_cand_lsu),
    .i_age   (r_age),
    .o_valid (w_lsu_found),
    .o_idx   (w_lsu_pick)
  );

  assign w_alu_fire = w_alu_found & alu_valid_i;
  assign w_mul_fire = w_mul_found & mul_valid_i & (r_mul_cnt == '0);

  always_comb begin
    w_lsu_state_nxt = r_lsu_state;
    w_lsu_load      = 1'b0;
    w_lsu_done      = 1'b0;
    case (r_lsu_state)
      LSU_IDLE: begin
        if (w_lsu_found) begin
          w_lsu_state_nxt = LSU_WAIT;
          w_lsu_load      = 1'b1;
        end
      end
      LSU_WAIT: begin
        if (lsu_ack_i) begin
          w_lsu_state_nxt = LSU_IDLE;
          w_lsu_done      = 1'b1;
        end
      end
      default: w_lsu_state_nxt = LSU_IDLE;
    endcase
  end

  always_comb begin
    w_clr_nxt = '0;
    if (w_alu_fire) begin
      w_clr_nxt = w_clr_nxt | (RS_SIZE'(1) << w_alu_pick);
    end
    if (w_mul_fire) begin
      w_clr_nxt = w_clr_nxt | (RS_SIZE'(1) << w_mul_pick);
    end
    if (w_lsu_done) begin
      w_clr_nxt = w_clr_nxt | (RS_SIZE'(1) << r_lsu_idx);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_alu_req   <= 1'b0;
      r_alu_idx   <= '0;
      r_mul_req   <= 1'b0;
      r_mul_idx   <= '0;
      r_mul_cnt   <= '0;
      r_lsu_state <= LSU_IDLE;
      r_lsu_idx   <= '0;
      r_clr       <= '0;
    end else begin
      r_alu_req <= w_alu_fire;
      if (w_alu_fire) begin
        r_alu_idx <= w_alu_pick;
      end
      r_mul_req <= w_mul_fire;
      if (w_mul_fire) begin
        r_mul_idx <= w_mul_pick;
        r_mul_cnt <= CNTW'(MUL_LAT);
      end else if (r_mul_cnt != '0) begin
        r_mul_cnt <= r_mul_cnt - CNTW'(1);
      end
      r_lsu_state <= w_lsu_state_nxt;
      if (w_lsu_load) begin
        r_lsu_idx <= w_lsu_pick;
      end
      r_clr <= w_clr_nxt;
    end
  end

  // New allocation becomes the youngest: every other entry is older than it,
  // and it is older than nobody. Row clear follows the column set so the
  // diagonal stays zero.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_age <= '0;
    end else if (alloc_en_i) begin
      for (int unsigned j = 0; j < RS_SIZE; j++) begin
        if (IDXW'(j) != alloc_idx_i) begin
          r_age[j][alloc_idx_i] <= 1'b1;
        end
      end
      r_age[alloc_idx_i] <= '0;
    end
  end

  assign alu_request_o = r_alu_req;
  assign alu_idx_o     = r_alu_idx;
  assign mul_request_o = r_mul_req;
  assign mul_idx_o     = r_mul_idx;
  assign mul_busy_o    = (r_mul_cnt != '0);
  assign lsu_request_o = (r_lsu_state == LSU_WAIT);
  assign lsu_idx_o     = r_lsu_idx;
  assign issue_clr_o   = r_clr;

endmodule
